// File: rtl/touch_key_ctrl.sv
// touch_key_ctrl: conditions the raw touch pad for the breathing-LED controller.
// The pad is synchronised into sys_clk and debounced on both edges by a small FSM.
// The block then produces:
//   - a one-cycle key_flag per validated press;
//   - a one-cycle key_long once per press held past the long threshold;
//   - led_en, a level that toggles on every key_flag;
//   - beep, a fixed-length strobe that is retriggered by every key_flag.
// fsm_state exposes the debounce FSM: 0 IDLE, 1 PRESS_DEB, 2 HELD, 3 RELEASE_DEB.
// No valid/ready handshakes exist here; every output is a plain registered level or pulse.

module touch_key_ctrl #(
    parameter logic [19:0] CNT_DEB_MAX  = 20'd999_999,
    parameter logic [25:0] CNT_LONG_MAX = 26'd49_999_999,
    parameter logic [22:0] CNT_BEEP_MAX = 23'd4_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       touch_key,
    output logic       key_flag,
    output logic       key_long,
    output logic       led_en,
    output logic       beep,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } state_t;

    localparam logic [19:0] DEB_ONE  = 20'd1;
    localparam logic [25:0] HOLD_ONE = 26'd1;
    localparam logic [22:0] BEEP_ONE = 23'd1;

    // Two-stage synchroniser; only key_s2 is used by the FSM.
    logic key_s1_q, key_s1_d;
    logic key_s2_q, key_s2_d;

    // Debounce FSM and its counters.
    state_t      state_q, state_d;
    logic [19:0] cnt_deb_q, cnt_deb_d;
    logic [25:0] cnt_hold_q, cnt_hold_d;
    logic        long_done_q, long_done_d;

    // Registered outputs.
    logic        key_flag_q, key_flag_d;
    logic        key_long_q, key_long_d;
    logic        led_en_q, led_en_d;
    logic        beep_q, beep_d;
    logic [22:0] cnt_beep_q, cnt_beep_d;

    // Synchroniser next-state: shift the pad through two flops.
    always_comb begin
        key_s1_d = touch_key;
        key_s2_d = key_s1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
        end else begin
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
        end
    end

    // FSM next-state, debounce/hold counters and the press/long-press pulses.
    always_comb begin
        state_d     = state_q;
        cnt_deb_d   = cnt_deb_q;
        cnt_hold_d  = cnt_hold_q;
        long_done_d = long_done_q;
        key_flag_d  = 1'b0;
        key_long_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_s2_q) begin
                    state_d = PRESS_DEB;
                end
            end

            PRESS_DEB: begin
                if (!key_s2_q) begin
                    // Too short to be a touch: drop it without an event.
                    state_d = IDLE;
                end else if (cnt_deb_q == CNT_DEB_MAX) begin
                    state_d    = HELD;
                    key_flag_d = 1'b1;
                    cnt_hold_d = '0;
                end else begin
                    cnt_deb_d = cnt_deb_q + DEB_ONE;
                end
            end

            HELD: begin
                // Hold time saturates at the threshold, so key_long can only fire once.
                if (cnt_hold_q != CNT_LONG_MAX) begin
                    cnt_hold_d = cnt_hold_q + HOLD_ONE;
                end else if (!long_done_q) begin
                    key_long_d  = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!key_s2_q) begin
                    state_d = RELEASE_DEB;
                end
            end

            RELEASE_DEB: begin
                if (key_s2_q) begin
                    // Bounce during release.
                    // Keep hold time and long_done so the press continues as one event.
                    state_d = HELD;
                end else if (cnt_deb_q == CNT_DEB_MAX) begin
                    state_d     = IDLE;
                    long_done_d = 1'b0;
                end else begin
                    cnt_deb_d = cnt_deb_q + DEB_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Each debounce window starts from zero in the new state.
        if (state_d != state_q) begin
            cnt_deb_d = '0;
        end
    end

    // FSM registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_deb_q   <= '0;
            cnt_hold_q  <= '0;
            long_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_deb_q   <= cnt_deb_d;
            cnt_hold_q  <= cnt_hold_d;
            long_done_q <= long_done_d;
        end
    end

    // LED enable toggle and beep strobe.
    // Both are driven by key_flag_d so they change on the same edge as key_flag.
    always_comb begin
        led_en_d   = led_en_q ^ key_flag_d;
        beep_d     = beep_q;
        cnt_beep_d = cnt_beep_q;

        if (key_flag_d) begin
            // A new press restarts the strobe even if one is already running.
            beep_d     = 1'b1;
            cnt_beep_d = '0;
        end else if (beep_q) begin
            if (cnt_beep_q == CNT_BEEP_MAX) begin
                beep_d     = 1'b0;
                cnt_beep_d = '0;
            end else begin
                cnt_beep_d = cnt_beep_q + BEEP_ONE;
            end
        end
    end

    // Output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_flag_q <= 1'b0;
            key_long_q <= 1'b0;
            led_en_q   <= 1'b0;
            beep_q     <= 1'b0;
            cnt_beep_q <= '0;
        end else begin
            key_flag_q <= key_flag_d;
            key_long_q <= key_long_d;
            led_en_q   <= led_en_d;
            beep_q     <= beep_d;
            cnt_beep_q <= cnt_beep_d;
        end
    end

    assign key_flag  = key_flag_q;
    assign key_long  = key_long_q;
    assign led_en    = led_en_q;
    assign beep      = beep_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_touch_key_ctrl.sv
// Bench for touch_key_ctrl with shortened timing parameters.
// u_dut    : DEB=5, LONG=20, BEEP=8.
// u_dut_rt : identical except BEEP=20. The longer strobe makes a second press
//            land inside a running beep, so the retrigger can be seen.
// A run-length reference model predicts every output on every cycle.
// It works from the synchronised key level:
//   - a press is accepted after DEB+2 consecutive high samples;
//   - a release completes after DEB+2 consecutive low samples;
//   - key_long fires on the (LONG+1)-th cycle spent in the held phase.

module tb_touch_key_ctrl;

  localparam int DEB   = 5;
  localparam int LONG  = 20;
  localparam int BEEP  = 8;
  localparam int BEEP2 = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       touch_key;
  logic       key_flag, key_long, led_en, beep;
  logic [1:0] fsm_state;
  logic       key_flag2, key_long2, led_en2, beep2;
  logic [1:0] fsm_state2;

  // clock / reset
  always #10 sys_clk = ~sys_clk;

  touch_key_ctrl #(
    .CNT_DEB_MAX (20'd5),
    .CNT_LONG_MAX(26'd20),
    .CNT_BEEP_MAX(23'd8)
  ) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .touch_key(touch_key),
    .key_flag (key_flag),
    .key_long (key_long),
    .led_en   (led_en),
    .beep     (beep),
    .fsm_state(fsm_state)
  );

  touch_key_ctrl #(
    .CNT_DEB_MAX (20'd5),
    .CNT_LONG_MAX(26'd20),
    .CNT_BEEP_MAX(23'd20)
  ) u_dut_rt (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .touch_key(touch_key),
    .key_flag (key_flag2),
    .key_long (key_long2),
    .led_en   (led_en2),
    .beep     (beep2),
    .fsm_state(fsm_state2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  // Observed event counters (from u_dut / u_dut_rt).
  int n_flag  = 0;
  int n_long  = 0;
  int n_beep  = 0;
  int n_beep2 = 0;

  // reference model state
  logic hist[$];
  logic m_last;
  int   m_run;
  bit   m_pressed;
  logic m_prev_s;
  int   m_held;
  bit   m_long_done;
  logic m_flag, m_long, m_led;
  int   m_beep_left, m_beep2_left;

  // scoreboard: expected output vectors, pushed by the model and popped per cycle
  logic [3:0] exp_q[$];
  logic [3:0] exp2_q[$];

  typedef struct {
    logic lvl;
    int   cyc;
    int   exp_flags;
    int   exp_longs;
    logic exp_led;
  } seg_t;

  seg_t tbl[19];

  task automatic check_eq(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_last       = 1'b0;
    m_run        = 0;
    m_pressed    = 0;
    m_prev_s     = 1'b0;
    m_held       = 0;
    m_long_done  = 0;
    m_flag       = 1'b0;
    m_long       = 1'b0;
    m_led        = 1'b0;
    m_beep_left  = 0;
    m_beep2_left = 0;
  endtask

  // One rising edge of the model; k is the pad level sampled on this edge.
  task automatic model_edge(input logic k);
    logic s;
    // The synchronised level seen before this edge is the pad level from two edges back.
    s = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
    hist.push_back(k);
    if (hist.size() > 2) void'(hist.pop_front());

    if (s == m_last) m_run++;
    else begin
      m_last = s;
      m_run  = 1;
    end

    m_flag = 1'b0;
    m_long = 1'b0;
    if (!m_pressed) begin
      if (s && m_run == DEB + 2) begin
        m_flag      = 1'b1;
        m_pressed   = 1;
        m_held      = 0;
        m_long_done = 0;
      end
    end else begin
      if (m_prev_s) begin
        m_held++;
        if (m_held == LONG + 1 && !m_long_done) begin
          m_long      = 1'b1;
          m_long_done = 1;
        end
      end
      if (!s && m_run == DEB + 2) m_pressed = 0;
    end
    m_prev_s = s;

    if (m_flag) m_led = ~m_led;
    m_beep_left  = m_flag ? BEEP + 1  : (m_beep_left  > 0 ? m_beep_left  - 1 : 0);
    m_beep2_left = m_flag ? BEEP2 + 1 : (m_beep2_left > 0 ? m_beep2_left - 1 : 0);

    exp_q.push_back({m_flag, m_long, m_led, m_beep_left > 0});
    exp2_q.push_back({m_flag, m_long, m_led, m_beep2_left > 0});
  endtask

  // driver: apply one pad level for one clock and compare after the edge
  task automatic step(input logic k);
    logic [3:0] e1, e2;
    touch_key = k;
    @(posedge sys_clk);
    model_edge(k);
    #1;
    n_steps++;
    e1 = exp_q.pop_front();
    e2 = exp2_q.pop_front();
    check_eq($sformatf("step%0d_outs", n_steps), {key_flag, key_long, led_en, beep}, e1);
    check_eq($sformatf("step%0d_outs_rt", n_steps), {key_flag2, key_long2, led_en2, beep2}, e2);
    check_eq($sformatf("step%0d_flag_long_excl", n_steps), key_flag & key_long, 0);
    n_flag  += int'(key_flag);
    n_long  += int'(key_long);
    n_beep  += int'(beep);
    n_beep2 += int'(beep2);
  endtask

  task automatic drive(input logic k, input int cyc);
    for (int i = 0; i < cyc; i++) step(k);
  endtask

  initial begin
    int f0, l0, b0, b20;
    logic lvl;

    // Segments (level, cycles, expected key_flag pulses, key_long pulses, led_en at end).
    tbl[0]  = '{1'b0,  5, 0, 0, 1'b0};
    tbl[1]  = '{1'b1,  1, 0, 0, 1'b0};  // ~20 ns glitch
    tbl[2]  = '{1'b0,  4, 0, 0, 1'b0};
    tbl[3]  = '{1'b1,  2, 0, 0, 1'b0};  // ~30-40 ns glitch
    tbl[4]  = '{1'b0,  4, 0, 0, 1'b0};
    tbl[5]  = '{1'b1,  3, 0, 0, 1'b0};  // ~50-60 ns glitch
    tbl[6]  = '{1'b0,  6, 0, 0, 1'b0};
    tbl[7]  = '{1'b1, 20, 1, 0, 1'b1};  // 400 ns press
    tbl[8]  = '{1'b0, 12, 0, 0, 1'b1};
    tbl[9]  = '{1'b1, 50, 1, 1, 1'b0};  // 1 us press, long press
    tbl[10] = '{1'b0, 12, 0, 0, 1'b0};
    tbl[11] = '{1'b1, 15, 1, 0, 1'b1};  // held press ...
    tbl[12] = '{1'b0,  2, 0, 0, 1'b1};  // ... 40 ns bounce ...
    tbl[13] = '{1'b1, 30, 0, 1, 1'b1};  // ... continues, reaches long
    tbl[14] = '{1'b0, 12, 0, 0, 1'b1};
    tbl[15] = '{1'b1,  9, 1, 0, 1'b0};  // first of two quick presses
    tbl[16] = '{1'b0,  7, 0, 0, 1'b0};
    tbl[17] = '{1'b1,  9, 1, 0, 1'b1};  // second press inside beep2 window
    tbl[18] = '{1'b0, 40, 0, 0, 1'b1};

    // reset
    model_reset();
    sys_rst_n = 1'b0;
    touch_key = 1'b0;
    #200;
    check_eq("reset_outs", {key_flag, key_long, led_en, beep}, 0);
    check_eq("reset_outs_rt", {key_flag2, key_long2, led_en2, beep2}, 0);
    check_eq("reset_state", fsm_state, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // table-driven segments
    for (int i = 0; i < 19; i++) begin
      f0 = n_flag;
      l0 = n_long;
      drive(tbl[i].lvl, tbl[i].cyc);
      check_eq($sformatf("seg%0d_flags", i), n_flag - f0, tbl[i].exp_flags);
      check_eq($sformatf("seg%0d_longs", i), n_long - l0, tbl[i].exp_longs);
      check_eq($sformatf("seg%0d_led", i), led_en, tbl[i].exp_led);
    end
    check_eq("idle_after_table", fsm_state, 0);

    // beep length of a single press: BEEP+1 and BEEP2+1 high cycles
    f0  = n_flag;
    b0  = n_beep;
    b20 = n_beep2;
    drive(1'b1, 12);
    drive(1'b0, 30);
    check_eq("beep_len_flags", n_flag - f0, 1);
    check_eq("beep_len", n_beep - b0, BEEP + 1);
    check_eq("beep_len_rt", n_beep2 - b20, BEEP2 + 1);

    // reset in the middle of a press, key still held afterwards
    drive(1'b1, 10);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_eq("midreset_outs", {key_flag, key_long, led_en, beep}, 0);
    check_eq("midreset_state", fsm_state, 0);
    model_reset();
    exp_q.delete();
    exp2_q.delete();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    f0 = n_flag;
    drive(1'b1, 12);
    drive(1'b0, 12);
    check_eq("midreset_flags", n_flag - f0, 1);
    check_eq("midreset_led", led_en, 1);

    // random segments against the model
    lvl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(lvl, int'($urandom_range(1, 35)));
      lvl = ~lvl;
    end
    drive(1'b0, 15);
    check_eq("final_idle", fsm_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
